// File: rtl/button_pulse_pkg.sv
// ---------------------------------------------------------------------------
// button_pulse_pkg
// Shared definitions for the pushbutton debounce / press-pulse block.
//   state_t          : 2-bit FSM state encoding (IDLE=0, PRESS_CHK=1,
//                      HELD=2, REL_CHK=3)
//   CNT_MAX_DEFAULT  : default stable-sample count (10 ms at 100 MHz)
// ---------------------------------------------------------------------------
package button_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CHK = 2'd1,
        HELD      = 2'd2,
        REL_CHK   = 2'd3
    } state_t;

    localparam int CNT_MAX_DEFAULT = 1000000;

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level input.
// Ports:
//   clk : sampling clock, rising edge
//   rst : synchronous, active-low reset (clears both flops)
//   d   : asynchronous input
//   q   : synchronized output (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/button_pulse.sv
// ---------------------------------------------------------------------------
// button_pulse
// Debounces a raw pushbutton and emits one registered strobe per accepted
// press. A level change is accepted only after CNT_MAX consecutive stable
// samples of the synchronized input.
// Parameters:
//   CNT_MAX : stable-sample cycles needed to accept a change (2..2^24-1)
//   CNT_W   : debounce counter width, >= ceil(log2(CNT_MAX))
// Ports:
//   clk       : sole clock, rising edge
//   rst       : synchronous, active-low reset
//   btn_in    : raw, bouncy, asynchronous button input
//   pulse     : one-cycle strobe per accepted press (to op-select change_in)
//   level     : debounced button level (1 in HELD / REL_CHK)
//   press_cnt : count of accepted presses, wraps 255 -> 0
// ---------------------------------------------------------------------------
module button_pulse
    import button_pulse_pkg::*;
#(
    parameter int CNT_MAX = CNT_MAX_DEFAULT,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       pulse,
    output logic       level,
    output logic [7:0] press_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             s2;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pulse_nxt;
    logic             level_nxt;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (s2)
    );

    // Next-state / counter logic. The counter only runs in the two check
    // states and is cleared on every state change, so it stops at CNT_LAST.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (s2) state_nxt = PRESS_CHK;
            end
            PRESS_CHK: begin
                if (!s2) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HELD: begin
                cnt_nxt = '0;
                if (!s2) state_nxt = REL_CHK;
            end
            REL_CHK: begin
                // A bounce back to 1 returns to HELD without a new strobe.
                if (s2) begin
                    state_nxt = HELD;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // level is registered from the next state so it stays aligned with state.
    assign level_nxt = (state_nxt == HELD) || (state_nxt == REL_CHK);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            pulse     <= 1'b0;
            level     <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pulse <= pulse_nxt;
            level <= level_nxt;
            if (pulse_nxt) press_cnt <= press_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_button_pulse.sv
// ---------------------------------------------------------------------------
// tb_button_pulse
// Directed bench for button_pulse with CNT_MAX=4. Edge numbers below count
// rising clock edges after reset is released; outputs are sampled 1 time
// unit after each edge.
// ---------------------------------------------------------------------------
module tb_button_pulse;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       pulse;
    logic       level;
    logic [7:0] press_cnt;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int falls  = 0;
    logic pulse_d = 1'b0;
    logic level_d = 1'b0;

    always #5 clk = ~clk;

    button_pulse #(
        .CNT_MAX (4),
        .CNT_W   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .pulse     (pulse),
        .level     (level),
        .press_cnt (press_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse must never be high on two consecutive cycles; also tally pulses
    // and falling edges of level for the scenario checks.
    always @(negedge clk) begin
        check_eq("no_double_pulse", 32'(pulse_d & pulse), 32'd0);
        if (pulse === 1'b1) pulses++;
        if (level_d === 1'b1 && level === 1'b0) falls++;
        pulse_d <= pulse;
        level_d <= level;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        btn_in = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
    endtask

    int p0;
    int f0;
    logic [6:0] rel_seq;

    initial begin
        // Reset state
        rst    = 1'b0;
        btn_in = 1'b1;
        repeat (3) tick();
        check_eq("rst_pulse", 32'(pulse), 32'd0);
        check_eq("rst_level", 32'(level), 32'd0);
        check_eq("rst_press_cnt", 32'(press_cnt), 32'd0);

        // Clean press: pulse only after edge 7, level from edge 7
        do_reset();
        btn_in = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_eq("clean_pulse", 32'(pulse), 32'(e == 7));
            check_eq("clean_level", 32'(level), 32'(e >= 7));
        end
        check_eq("clean_press_cnt", 32'(press_cnt), 32'd1);

        // Release: low before edge k, level first 0 after edge k+6
        btn_in = 1'b0;
        for (int j = 0; j <= 8; j++) begin
            tick();
            check_eq("release_level", 32'(level), 32'(j < 6));
        end

        // Short bounce 1,1,0 never qualifies
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 40; i++) begin
            btn_in = (i % 3) != 2;
            tick();
            check_eq("bounce_level", 32'(level), 32'd0);
        end
        btn_in = 1'b0;
        repeat (5) tick();
        check_eq("bounce_pulses", 32'(pulses - p0), 32'd0);
        check_eq("bounce_press_cnt", 32'(press_cnt), 32'd0);

        // Long hold with release bounce
        do_reset();
        p0 = pulses;
        f0 = falls;
        btn_in = 1'b1;
        repeat (50) tick();
        check_eq("hold_level", 32'(level), 32'd1);
        rel_seq = 7'b0000010;  // applied LSB first: 0,1,0,0,0,0,0
        for (int i = 0; i < 7; i++) begin
            btn_in = rel_seq[i];
            tick();
        end
        btn_in = 1'b0;
        repeat (10) tick();
        check_eq("hold_pulses", 32'(pulses - p0), 32'd1);
        check_eq("hold_level_falls", 32'(falls - f0), 32'd1);
        check_eq("hold_press_cnt", 32'(press_cnt), 32'd1);
        check_eq("hold_level_end", 32'(level), 32'd0);

        // Reset mid-qualify at edge 5; next pulse after edge 12
        do_reset();
        btn_in = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check_eq("midrst_pulse", 32'(pulse), 32'd0);
        check_eq("midrst_level", 32'(level), 32'd0);
        check_eq("midrst_press_cnt", 32'(press_cnt), 32'd0);
        rst = 1'b1;
        for (int e = 6; e <= 14; e++) begin
            tick();
            check_eq("midrst_pulse_after", 32'(pulse), 32'(e == 12));
            check_eq("midrst_level_after", 32'(level), 32'(e >= 12));
        end

        // Wrap: 256 clean presses
        do_reset();
        p0 = pulses;
        for (int i = 0; i < 256; i++) begin
            btn_in = 1'b1;
            repeat (10) tick();
            btn_in = 1'b0;
            repeat (10) tick();
            if (i == 254) check_eq("wrap_press_cnt_255", 32'(press_cnt), 32'd255);
        end
        check_eq("wrap_pulses", 32'(pulses - p0), 32'd256);
        check_eq("wrap_press_cnt", 32'(press_cnt), 32'd0);
        check_eq("wrap_level", 32'(level), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_pulse.md
BUTTON_PULSE -- requirements
Module: button_pulse

Interface
REQ-001 SHALL provide parameter CNT_MAX, default 1000000, meaning stable-sample cycles required to accept a level change (10 ms at 100 MHz); legal range 2..2^24-1.
REQ-002 SHALL provide parameter CNT_W, default 20, meaning debounce counter width; CNT_W SHALL be at least ceil(log2(CNT_MAX)).
REQ-003 SHALL provide port clk, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL provide port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL provide port btn_in, input, 1 bit: raw pushbutton, asynchronous to clk, bouncy.
REQ-006 SHALL provide port pulse, output, 1 bit: registered one-cycle strobe per accepted press; drives the change_in input of the downstream op-select FSM.
REQ-007 SHALL provide port level, output, 1 bit: registered debounced button level.
REQ-008 SHALL provide port press_cnt, output, 8 bits: registered count of accepted presses.

Function
REQ-009 SHALL pass btn_in through a 2-flop synchronizer (s1, s2); all other logic SHALL use s2 only.
REQ-010 SHALL implement a 4-state FSM: IDLE, PRESS_CHK, HELD, REL_CHK.
REQ-011 IDLE: s2=1 -> PRESS_CHK with cnt cleared to 0; otherwise stay.
REQ-012 PRESS_CHK: s2=0 -> IDLE with cnt cleared (bounce rejected); s2=1 and cnt<CNT_MAX-1 -> cnt+1; s2=1 and cnt=CNT_MAX-1 -> HELD with cnt cleared.
REQ-013 HELD: s2=0 -> REL_CHK with cnt cleared; otherwise stay, cnt held at 0.
REQ-014 REL_CHK: s2=1 -> HELD with cnt cleared, with no new pulse; s2=0 and cnt<CNT_MAX-1 -> cnt+1; s2=0 and cnt=CNT_MAX-1 -> IDLE with cnt cleared.
REQ-015 pulse SHALL be 1 for exactly the one cycle following the PRESS_CHK->HELD edge, and 0 at all other times.
REQ-016 level SHALL be 1 when state is HELD or REL_CHK, and 0 when state is IDLE or PRESS_CHK; level SHALL be registered and aligned with state.
REQ-017 Latency: with btn_in stable high from before clock edge 1, pulse and level SHALL first read 1 after edge CNT_MAX+3.
REQ-018 Release latency: with btn_in stable low from before edge k (state HELD), level SHALL first read 0 after edge k+CNT_MAX+2.
REQ-019 press_cnt SHALL increment by 1 in the same edge that sets pulse, and SHALL wrap 255->0 with no flag.
REQ-020 A held button SHALL produce exactly one pulse, with no auto-repeat, regardless of hold duration.
REQ-021 cnt SHALL never exceed CNT_MAX-1 and SHALL never wrap.

Reset
REQ-022 When rst=0 at a rising edge, the block SHALL set s1=0, s2=0, state=IDLE, cnt=0, pulse=0, level=0, and press_cnt=0.
REQ-023 Reset SHALL take priority over all FSM transitions, including mid-PRESS_CHK and mid-REL_CHK.
REQ-024 After reset, the next pulse SHALL require a full press qualification per REQ-017.

Structure
REQ-025 A shared package SHALL hold the state encoding (2-bit, IDLE=0, PRESS_CHK=1, HELD=2, REL_CHK=3) and the CNT_MAX default.
REQ-026 The synchronizer SHALL be a separate sub-module sync_2ff (clk, rst, d, q), reusable for the sel switch inputs.
REQ-027 The FSM and counters SHALL reside in button_pulse itself; no other sub-modules.

Verification (bench CNT_MAX=4)
REQ-028 Clean press: reset, then btn_in=1 held from edge 1 -> pulse=1 only after edge 7, level=1 from edge 7, press_cnt=1.
REQ-029 Short bounce: btn_in pattern 1,1,0 repeated for 40 cycles, then 0 -> pulse never 1, level stays 0, press_cnt=0.
REQ-030 Long hold with release bounce: hold 1 for 50 cycles, then 0,1,0,0,0,0,0 -> exactly one pulse, level falls once, press_cnt=1.
REQ-031 Reset mid-qualify: btn_in=1, assert rst=0 at edge 5 for 1 cycle -> all outputs 0 at edge 5; pulse first after edge 5+7=12 with btn_in still 1.
REQ-032 Wrap: 256 clean press/release cycles -> 256 single pulses, press_cnt=0 at end.
REQ-033 The bench SHALL assert that pulse is never high for two consecutive cycles.
